// File: rtl/spi_tx.sv
// SPI frame transmitter: sends a wake-up edge, the instruction address MSB first,
// then the branch direction bit, with sclk derived from clk by a half-period divider.
module spi_tx #(
   parameter int NUM_ADDR_BITS = 16,
   parameter int HALF_PERIOD   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [NUM_ADDR_BITS-1:0] inst_addr_in,
   input  logic                     direction_in,
   output logic                     busy,
   output logic                     done,
   output logic                     cs,
   output logic                     mosi,
   output logic                     sclk
);

   localparam int                EDGE_W       = $clog2(NUM_ADDR_BITS + 2);
   localparam logic [EDGE_W-1:0] EDGE_LAST    = EDGE_W'(NUM_ADDR_BITS + 1);
   localparam logic [EDGE_W-1:0] CS_HIGH_FROM = EDGE_W'(NUM_ADDR_BITS - 1);
   localparam logic [7:0]        HALF_LAST    = 8'(HALF_PERIOD - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                  state, state_nxt;
   logic [7:0]              half_cnt, half_cnt_nxt;
   logic [EDGE_W-1:0]       edge_cnt, edge_cnt_nxt;
   logic [NUM_ADDR_BITS:0]  shadow, shadow_nxt;
   logic                    cs_nxt, mosi_nxt, sclk_nxt, done_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         half_cnt <= '0;
         edge_cnt <= '0;
         cs       <= 1'b1;
         mosi     <= 1'b0;
         sclk     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         half_cnt <= half_cnt_nxt;
         edge_cnt <= edge_cnt_nxt;
         cs       <= cs_nxt;
         mosi     <= mosi_nxt;
         sclk     <= sclk_nxt;
         done     <= done_nxt;
      end
   end

   // Frame payload {addr, direction}; its MSB is the next bit to present on mosi.
   always_ff @(posedge clk) begin
      shadow <= shadow_nxt;
   end

   always_comb begin
      state_nxt    = state;
      half_cnt_nxt = half_cnt;
      edge_cnt_nxt = edge_cnt;
      shadow_nxt   = shadow;
      cs_nxt       = cs;
      mosi_nxt     = mosi;
      sclk_nxt     = sclk;
      done_nxt     = 1'b0;

      case (state)
         IDLE: begin
            cs_nxt       = 1'b1;
            mosi_nxt     = 1'b0;
            sclk_nxt     = 1'b0;
            half_cnt_nxt = '0;
            edge_cnt_nxt = '0;
            if (start) begin
               state_nxt  = SHIFT;
               shadow_nxt = {inst_addr_in, direction_in};
               cs_nxt     = 1'b0;
            end
         end

         SHIFT: begin
            if (half_cnt == HALF_LAST) begin
               half_cnt_nxt = '0;
               if (!sclk) begin
                  sclk_nxt = 1'b1;
               end else begin
                  sclk_nxt = 1'b0;
                  if (edge_cnt == EDGE_LAST) begin
                     state_nxt    = IDLE;
                     done_nxt     = 1'b1;
                     cs_nxt       = 1'b1;
                     mosi_nxt     = 1'b0;
                     edge_cnt_nxt = '0;
                  end else begin
                     // Start of the next edge's low phase: the only point cs/mosi move.
                     edge_cnt_nxt = edge_cnt + 1'b1;
                     mosi_nxt     = shadow[NUM_ADDR_BITS];
                     shadow_nxt   = {shadow[NUM_ADDR_BITS-1:0], 1'b0};
                     cs_nxt       = (edge_cnt >= CS_HIGH_FROM);
                  end
               end
            end else begin
               half_cnt_nxt = half_cnt + 8'd1;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_tx.sv
// Scoreboard bench for spi_tx: stimulus pushes expected frames, a receiver-model
// monitor rebuilds each frame from sclk rising edges and compares on done.
module tb_spi_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start_v, dir_v, busy_v, done_v, cs_v, mosi_v, sclk_v;
   logic [15:0] addr_v [2];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   typedef struct {
      logic [15:0] addr;
      logic        dir;
      int          done_cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_tx #(.NUM_ADDR_BITS(16), .HALF_PERIOD(2)) u_hp2 (
      .clk(clk), .rst(rst), .start(start_v[0]), .inst_addr_in(addr_v[0]),
      .direction_in(dir_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .cs(cs_v[0]), .mosi(mosi_v[0]), .sclk(sclk_v[0]));

   spi_tx #(.NUM_ADDR_BITS(16), .HALF_PERIOD(1)) u_hp1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .inst_addr_in(addr_v[1]),
      .direction_in(dir_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .cs(cs_v[1]), .mosi(mosi_v[1]), .sclk(sclk_v[1]));

   task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] req);
      n_chk++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s dut%0d: got 0x%0h, required 0x%0h (cycle %0d)", nm, i, got, req, cyc);
      end
   endtask

   function automatic int hp(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic void push(input int i, input exp_t e);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   function automatic exp_t pop(input int i);
      if (i == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   // Receiver model
   int          nedge [2];
   int          ndone [2];
   logic [17:0] mbits [2];
   logic [17:0] cbits [2];
   logic [1:0]  psclk = 2'b00;

   initial begin
      for (int i = 0; i < 2; i++) begin
         nedge[i] = 0;
         ndone[i] = 0;
         mbits[i] = '0;
         cbits[i] = '0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            nedge[i] = 0;
         end else begin
            if (sclk_v[i] && !psclk[i]) begin
               if (nedge[i] < 18) begin
                  mbits[i][nedge[i]] = mosi_v[i];
                  cbits[i][nedge[i]] = cs_v[i];
               end
               nedge[i]++;
            end
            if (done_v[i]) begin
               ndone[i]++;
               if (qsize(i) == 0) begin
                  chk("unexpected_done", i, 32'd1, 32'd0);
               end else begin
                  exp_t        e;
                  logic [15:0] rx;
                  e  = pop(i);
                  rx = '0;
                  for (int k = 1; k <= 16; k++) rx = {rx[14:0], mbits[i][k]};
                  chk("edge_count", i, nedge[i], 18);
                  chk("done_cycle", i, cyc, e.done_cyc);
                  chk("cs_pattern", i, {14'd0, cbits[i]}, 32'h0003_0000);
                  chk("wake_mosi", i, {31'd0, mbits[i][0]}, 32'd0);
                  chk("rx_addr", i, {16'd0, rx}, {16'd0, e.addr});
                  chk("rx_dir", i, {31'd0, mbits[i][17]}, {31'd0, e.dir});
                  chk("done_lines", i, {busy_v[i], cs_v[i], sclk_v[i], mosi_v[i]}, 32'b0100);
               end
               nedge[i] = 0;
            end
         end
         psclk[i] = sclk_v[i];
      end
   end

   task automatic launch(input int i, input logic [15:0] a, input logic d);
      exp_t e;
      @(posedge clk); #1;
      addr_v[i]  = a;
      dir_v[i]   = d;
      start_v[i] = 1'b1;
      e.addr = a; e.dir = d; e.done_cyc = cyc + 1 + 36 * hp(i);
      push(i, e);
      @(posedge clk); #1;
      start_v[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i, input int bound);
      for (int k = 0; k < bound && qsize(i) != 0; k++) @(negedge clk);
      if (qsize(i) != 0) begin
         chk("frame_timeout", i, 32'd1, 32'd0);
         if (i == 0) q0.delete();
         else        q1.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   p;
      rst       = 1'b1;
      start_v   = 2'b00;
      dir_v     = 2'b00;
      addr_v[0] = '0;
      addr_v[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_lines", i, {busy_v[i], done_v[i], cs_v[i], sclk_v[i], mosi_v[i]}, 32'b00100);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic frame
      launch(0, 16'hA5C3, 1'b1);
      chk("busy_after_start", 0, {31'd0, busy_v[0]}, 32'd1);
      wait_idle(0, 200);

      // Back-to-back with start held through done
      @(posedge clk); #1;
      addr_v[0] = 16'h0000; dir_v[0] = 1'b0; start_v[0] = 1'b1;
      p = cyc + 1;
      e.addr = 16'h0000; e.dir = 1'b0; e.done_cyc = p + 72;
      push(0, e);
      while (cyc < p + 72) @(negedge clk);
      addr_v[0] = 16'hFFFF; dir_v[0] = 1'b1;
      e.addr = 16'hFFFF; e.dir = 1'b1; e.done_cyc = p + 73 + 72;
      push(0, e);
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      @(negedge clk);
      chk("b2b_cs_fall", 0, {31'd0, cs_v[0]}, 32'd0);
      chk("b2b_busy", 0, {31'd0, busy_v[0]}, 32'd1);
      wait_idle(0, 300);

      // Start while busy is ignored
      launch(0, 16'h5A3C, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      addr_v[0] = 16'h1234; dir_v[0] = 1'b1; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      wait_idle(0, 200);
      repeat (100) @(negedge clk);
      chk("idle_after_ignored", 0, {31'd0, busy_v[0]}, 32'd0);

      // Inputs scrambled every cycle after capture
      launch(0, 16'h3C96, 1'b1);
      for (int k = 0; k < 200 && q0.size() != 0; k++) begin
         @(posedge clk); #1;
         addr_v[0] = 16'($urandom);
         dir_v[0]  = 1'($urandom);
      end
      wait_idle(0, 50);

      // Reset in the middle of the frame, as E8 would rise
      launch(0, 16'h6B2D, 1'b0);
      repeat (33) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q0.delete();
      @(negedge clk);
      chk("midreset_lines", 0, {busy_v[0], done_v[0], cs_v[0], sclk_v[0], mosi_v[0]}, 32'b00100);
      repeat (100) @(negedge clk);
      launch(0, 16'h0F0F, 1'b1);
      wait_idle(0, 200);

      // Divider corner, HALF_PERIOD=1
      launch(1, 16'h8001, 1'b0);
      chk("hp1_sclk_low_phase", 1, {31'd0, sclk_v[1]}, 32'd0);
      @(posedge clk); #1;
      chk("hp1_sclk_toggle", 1, {31'd0, sclk_v[1]}, 32'd1);
      wait_idle(1, 100);

      repeat (50) @(negedge clk);
      chk("done_total", 0, ndone[0], 6);
      chk("done_total", 1, ndone[1], 1);
      chk("queue_empty", 0, q0.size(), 0);
      chk("queue_empty", 1, q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
